// File: rtl/spi_master_sched_if.sv
// Bundle between the SPI master scheduler, its two requesters and the SPI pins.
// Latency: none, wires only.
// Backpressure: requests are level-held until the scheduler pulses req_ready.
// Ports: master = scheduler side, slave = requester / pin side.
interface spi_master_sched_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        req_valid;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              SPI_CS;
  logic              SPI_SCK;
  logic              SPI_MOSI;
  logic              SPI_MISO;

  modport master (
    input  req_valid, req_data0, req_data1, SPI_MISO,
    output req_ready, rsp_valid, rsp_data, busy, SPI_CS, SPI_SCK, SPI_MOSI
  );

  modport slave (
    output req_valid, req_data0, req_data1, SPI_MISO,
    input  req_ready, rsp_valid, rsp_data, busy, SPI_CS, SPI_SCK, SPI_MOSI
  );
endinterface

// File: rtl/spi_master_sched.sv
// Two-requester SPI mode-0 master: arbitrates, runs one full-duplex byte frame, returns MISO byte.
// Latency: accept-to-response CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD cycles, then CS_GAP idle cycles.
// Backpressure: req_valid is held until the one-cycle req_ready pulse; requests wait while busy.
// Ports: clk, rst_n (synchronous, active-high despite the name), bus (spi_master_sched_if.master):
//   req_valid/req_data0/req_data1 in, req_ready/rsp_valid/rsp_data/busy out, SPI_CS/SCK/MOSI out, SPI_MISO in.
// Build option: define SPI_FIXED_PRIO_EN for strict priority (requester 0 wins ties);
//   otherwise ties are broken round-robin.
module spi_master_sched #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 20,
  parameter int CS_SETUP = 20,
  parameter int CS_HOLD  = 100,
  parameter int CS_GAP   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_sched_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int TOG_W = $clog2(2 * DATA_W + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TOG_W-1:0]  tog_cnt;
  // Holds only the bits still to be sent; the bit on the wire lives in mosi_q.
  logic [DATA_W-2:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              gnt;
  logic              cs_q;
  logic              sck_q;
  logic              mosi_q;
  logic              busy_q;
  logic [1:0]        req_ready_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              win;
  logic [DATA_W-1:0] tx_byte;

`ifdef SPI_FIXED_PRIO_EN
  always_comb begin
    win = bus.req_valid[0] ? 1'b0 : 1'b1;
  end
`else
  logic last_gnt;
  // On a tie the requester that was not served last wins; a lone requester always wins.
  always_comb begin
    if (bus.req_valid == 2'b11) win = ~last_gnt;
    else                        win = bus.req_valid[1];
  end
`endif

  assign tx_byte = win ? bus.req_data1 : bus.req_data0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tog_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      gnt         <= 1'b0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
`ifndef SPI_FIXED_PRIO_EN
      last_gnt    <= 1'b1;
`endif
    end else begin
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt         <= win;
`ifndef SPI_FIXED_PRIO_EN
            last_gnt    <= win;
`endif
            req_ready_q <= win ? 2'b10 : 2'b01;
            tx_sr       <= tx_byte[DATA_W-2:0];
            mosi_q      <= tx_byte[DATA_W-1];
            rx_sr       <= '0;
            cs_q        <= 1'b0;
            busy_q      <= 1'b1;
            cnt         <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt     <= '0;
            tog_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt     <= '0;
            sck_q   <= ~sck_q;
            tog_cnt <= tog_cnt + 1'b1;
            // Even toggle index = SCK rising edge (sample), odd = falling edge (launch).
            if (!tog_cnt[0]) begin
              rx_sr <= {rx_sr[DATA_W-2:0], bus.SPI_MISO};
            end else if (tog_cnt == TOG_W'(2 * DATA_W - 1)) begin
              // Last falling edge: MOSI keeps its final bit through HOLD.
              state <= HOLD;
            end else begin
              mosi_q <= tx_sr[DATA_W-2];
              tx_sr  <= {tx_sr[DATA_W-3:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            cnt         <= '0;
            cs_q        <= 1'b1;
            rsp_data_q  <= rx_sr;
            rsp_valid_q <= gnt ? 2'b10 : 2'b01;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cs_q   <= 1'b1;
          sck_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.SPI_CS    = cs_q;
  assign bus.SPI_SCK   = sck_q;
  assign bus.SPI_MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched: reset, loopback frame, slave echo, gap, mid-frame reset, arbitration.
// Latency: frames expected 440 cycles accept-to-response, 461 accept-to-accept with default parameters.
// Backpressure: requests are held by the bench until req_ready or deliberately withdrawn.
module tb_spi_master_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_sched_if #(.DATA_W(8)) bus ();

  spi_master_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MISO source: loopback from MOSI, or a mode-0 slave that echoes slv_byte.
  logic       loopback = 1'b1;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_byte = 8'h3C;
  logic [7:0] slv_tx   = 8'h00;
  logic [7:0] slv_rx   = 8'h00;

  assign bus.SPI_MISO = loopback ? bus.SPI_MOSI : slv_miso;

  always @(negedge bus.SPI_CS) begin
    slv_tx   = slv_byte;
    slv_miso = slv_tx[7];
  end
  always @(posedge bus.SPI_SCK) if (!bus.SPI_CS) slv_rx = {slv_rx[6:0], bus.SPI_MOSI};
  always @(negedge bus.SPI_SCK) if (!bus.SPI_CS) begin
    slv_tx   = {slv_tx[6:0], 1'b0};
    slv_miso = slv_tx[7];
  end

  // Cycle counter and passive monitor (samples on the falling clk edge).
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         acc_cyc[$];
  logic [1:0] acc_g[$];
  int         rsp_cyc[$];
  logic [7:0] rsp_d[$];
  int         sck_cyc[$];
  logic [7:0] mosi_rise = 8'h00;
  int         cs_low = 0;
  logic       sck_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.req_ready != 2'b00) begin
      acc_cyc.push_back(cyc);
      acc_g.push_back(bus.req_ready);
    end
    if (bus.rsp_valid != 2'b00) begin
      rsp_cyc.push_back(cyc);
      rsp_d.push_back(bus.rsp_data);
    end
    if (bus.SPI_CS === 1'b0) cs_low++;
    if (bus.SPI_SCK !== sck_prev) begin
      sck_cyc.push_back(cyc);
      if (bus.SPI_SCK === 1'b1) mosi_rise = {mosi_rise[6:0], bus.SPI_MOSI};
    end
    sck_prev = bus.SPI_SCK;
  end

  task automatic clear_mon();
    acc_cyc.delete();
    acc_g.delete();
    rsp_cyc.delete();
    rsp_d.delete();
    sck_cyc.delete();
    cs_low = 0;
  endtask

  int r_cyc;
  int a_cyc;
  int bad;
  logic [1:0] exp_g;
  logic [7:0] exp_d;

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;

    // ---- reset state ----
    repeat (5) @(negedge clk);
    check_vec("rst_cs",   32'(bus.SPI_CS),    32'h1);
    check_vec("rst_sck",  32'(bus.SPI_SCK),   32'h0);
    check_vec("rst_mosi", 32'(bus.SPI_MOSI),  32'h0);
    check_vec("rst_busy", 32'(bus.busy),      32'h0);
    check_vec("rst_rdy",  32'(bus.req_ready), 32'h0);
    check_vec("rst_rsp",  32'(bus.rsp_valid), 32'h0);
    check_vec("rst_data", 32'(bus.rsp_data),  32'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // ---- single loopback frame, A5 ----
    clear_mon();
    loopback      = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'hA5;
    @(negedge clk);
    check_vec("lb_ready", 32'(bus.req_ready), 32'h1);
    check_vec("lb_busy",  32'(bus.busy),      32'h1);
    check_vec("lb_cs",    32'(bus.SPI_CS),    32'h0);
    check_vec("lb_mosi0", 32'(bus.SPI_MOSI),  32'h1);
    bus.req_valid = 2'b00;
    repeat (470) @(negedge clk);
    check_vec("lb_nacc",  32'(acc_cyc.size()), 32'd1);
    check_vec("lb_nrsp",  32'(rsp_cyc.size()), 32'd1);
    if (acc_cyc.size() == 1 && rsp_cyc.size() == 1) begin
      check_vec("lb_lat",  32'(rsp_cyc[0] - acc_cyc[0]), 32'd440);
      check_vec("lb_data", 32'(rsp_d[0]),               32'hA5);
    end
    check_vec("lb_cslow", 32'(cs_low),          32'd440);
    check_vec("lb_nsck",  32'(sck_cyc.size()),  32'd16);
    if (sck_cyc.size() > 0 && acc_cyc.size() > 0)
      check_vec("lb_rise0", 32'(sck_cyc[0] - acc_cyc[0]), 32'd40);
    bad = 0;
    for (int i = 1; i < sck_cyc.size(); i++)
      if (sck_cyc[i] - sck_cyc[i-1] != 20) bad++;
    check_vec("lb_halfp", 32'(bad), 32'd0);
    check_vec("lb_mosi",  32'(mosi_rise), 32'hA5);
    check_vec("lb_idle",  32'(bus.busy),  32'h0);
    check_vec("lb_sckend", 32'(bus.SPI_SCK), 32'h0);

    // ---- slave echo, then request right after rsp_valid (gap) ----
    loopback      = 1'b0;
    slv_byte      = 8'h3C;
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'h96;
    @(negedge clk);
    bus.req_valid = 2'b00;
    r_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        r_cyc = cyc;
        break;
      end
    end
    check_vec("echo_seen", 32'(r_cyc >= 0), 32'h1);
    check_vec("echo_data", 32'(bus.rsp_data), 32'h3C);
    check_vec("echo_slv",  32'(slv_rx),       32'h96);
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'h0F;
    a_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        a_cyc = cyc;
        break;
      end
    end
    bus.req_valid = 2'b00;
    check_vec("gap_space", 32'(a_cyc - r_cyc), 32'd21);
    repeat (470) @(negedge clk);
    check_vec("gap_data", 32'(bus.rsp_data), 32'h3C);
    check_vec("gap_slv",  32'(slv_rx),       32'h0F);

    // ---- reset in the middle of SHIFT ----
    clear_mon();
    loopback      = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'h5A;
    @(negedge clk);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sck_cyc.size() >= 5) break;
    end
    check_vec("mid_nsck", 32'(sck_cyc.size()), 32'd5);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("mid_cs",   32'(bus.SPI_CS),  32'h1);
    check_vec("mid_sck",  32'(bus.SPI_SCK), 32'h0);
    check_vec("mid_busy", 32'(bus.busy),    32'h0);
    rst_n = 1'b0;
    repeat (500) @(negedge clk);
    check_vec("mid_norsp", 32'(rsp_cyc.size()), 32'd0);

    // ---- arbitration, both requesters held ----
    clear_mon();
    bus.req_data0 = 8'h11;
    bus.req_data1 = 8'h22;
    bus.req_valid = 2'b11;
    repeat (1500) @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (600) @(negedge clk);
    check_vec("arb_nacc", 32'(acc_cyc.size()), 32'd4);
    check_vec("arb_nrsp", 32'(rsp_cyc.size()), 32'd4);
    for (int i = 0; i < acc_g.size() && i < 4; i++) begin
`ifdef SPI_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_d = (exp_g == 2'b01) ? 8'h11 : 8'h22;
      check_vec($sformatf("arb_g%0d", i), 32'(acc_g[i]), 32'(exp_g));
      if (i < rsp_d.size())
        check_vec($sformatf("arb_d%0d", i), 32'(rsp_d[i]), 32'(exp_d));
      if (i > 0)
        check_vec($sformatf("arb_sp%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd461);
    end
    check_vec("arb_idle", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
